par2serial_gear: RTL and testbench
==================================

// Module: par2serial_gear
// PURPOSE
//  Parametrised parallel-to-serial gearbox that replaces the fixed 16->8 converter.
//  Accepts an IN_W-bit word through a valid/ready handshake and emits it as RATIO = IN_W/OUT_W
//  OUT_W-bit beats. Beat order is MSB-first or LSB-first, and an output handshake applies backpressure.
//  Sits between a wide datapath producer and a narrow link or serial-framing stage.
// PARAMETERS
//  IN_W   16  input word width; must be an integer multiple of OUT_W
//  OUT_W  8   output beat width; RATIO = IN_W/OUT_W must be >= 2
//  CNT_W  $clog2(IN_W/OUT_W)  beat-counter width (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-low reset
//  in_data    in   IN_W   parallel word
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block can take a word this cycle
//  msb_first  in   1      1: most-significant slice first; 0: least-significant first; sampled at load
//  out_data   out  OUT_W  current beat
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts beat
//  out_last   out  1      current beat is the final slice of the word
//  out_parity out  1      even parity (XOR) of out_data; present only with P2S_PARITY_EN
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; shift reg, counter and out_data = 0; out_valid=0, out_last=0; in_ready=1.
//  States:
//   IDLE: out_valid=0. in_valid&in_ready loads in_data into the shift register, latches msb_first,
//         sets cnt=RATIO-1 and moves to SHIFT.
//   SHIFT: out_valid=1. On out_valid&out_ready:
//    - cnt>0: shift by OUT_W (left if MSB-first, right if LSB-first; zero fill); cnt--.
//    - cnt==0 with in_valid: reload the new word and stay in SHIFT (back-to-back).
//    - cnt==0 without in_valid: go to IDLE.
//  in_ready = (state==IDLE) | (out_valid & out_ready & out_last); combinational, no loop through in_valid.
//  out_data = sreg[IN_W-1 -: OUT_W] if MSB-first, otherwise sreg[OUT_W-1:0]. Registered; it is the
//   register slice, so there is no comb path from inputs.
//  out_last = out_valid & (cnt==0).
//  Latency: word accepted at edge N; first beat valid in the cycle after edge N.
//  Throughput: one word per RATIO cycles with in_valid=out_ready=1 continuously; no bubble between words.
//  Backpressure: while out_valid&~out_ready, out_data, out_last, cnt and state hold stable.
//  in_data and msb_first changing mid-word have no effect; both are captured only at load.
//  Reset mid-word drops the partial word; no further beats of it appear after rst releases.
//  Elaboration: IN_W%OUT_W!=0 or IN_W/OUT_W<2 is a fatal error ($error in generate).
// CONFIGURATION
//  P2S_PARITY_EN defined: adds the out_parity port = ^out_data, registered with out_data (reset 0).
//  P2S_PARITY_EN undefined: no out_parity port or logic; all other behaviour is identical.
// TESTING
//  (IN_W=16, OUT_W=8, out_ready=1 unless stated)
//  1. Reset low for 4 cycles -> out_valid=0, out_data=8'h00, in_ready=1; release -> still idle.
//  2. 16'h3524, msb_first=1 -> beats 8'h35 (out_last=0), 8'h24 (out_last=1) on consecutive cycles.
//  3. 16'h3524, msb_first=0 -> beats 8'h24, 8'h35; out_last on 8'h35.
//  4. 16'h5e81 then 16'hd609 back-to-back, MSB-first -> 5e,81,d6,09 in 4 consecutive cycles;
//     in_ready=1 only on the 81 beat.
//  5. out_ready=0 for 3 cycles while showing 8'h5e -> out_data, out_valid and in_ready=0 held;
//     resume -> 8'h81 next.
//  6. rst=0 while beat 8'hd6 is pending -> out_valid=0 immediately; 8'h09 never emitted.
//     With P2S_PARITY_EN: 8'hd6 -> parity 1, 8'h09 -> 0.
//     Rebuild IN_W=32: 32'h7b0d998d, MSB-first -> 7b,0d,99,8d.

Source files
------------

// File: rtl/par2serial_gear.sv
// rtl/par2serial_gear.sv - IN_W to OUT_W parallel-to-serial gearbox with valid/ready on both sides.
// Optional even-parity output is enabled by defining P2S_PARITY_EN.
module par2serial_gear #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int CNT_W = $clog2(IN_W / OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             msb_first,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef P2S_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int RATIO = IN_W / OUT_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  generate
    if ((IN_W % OUT_W) != 0 || (IN_W / OUT_W) < 2) begin : g_bad_cfg
      $error("par2serial_gear: IN_W must be a multiple of OUT_W with ratio >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             msb_q, msb_d;
  logic             load;
  logic             beat_done;

  assign out_valid = (state_q == SHIFT);
  assign out_last  = out_valid & (cnt_q == '0);
  assign in_ready  = (state_q == IDLE) | (out_valid & out_ready & out_last);
  assign out_data  = msb_q ? sreg_q[IN_W-1 -: OUT_W] : sreg_q[OUT_W-1:0];

`ifdef P2S_PARITY_EN
  assign out_parity = ^out_data;
`endif

  assign load      = in_valid & in_ready;
  assign beat_done = out_valid & out_ready;

  // A load on the final beat covers the back-to-back reload case as well as IDLE.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    if (load) begin
      sreg_d  = in_data;
      msb_d   = msb_first;
      cnt_d   = LAST_CNT;
      state_d = SHIFT;
    end else if (beat_done) begin
      if (cnt_q != '0) begin
        sreg_d = msb_q ? (sreg_q << OUT_W) : (sreg_q >> OUT_W);
        cnt_d  = cnt_q - 1'b1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
    end
  end

endmodule

// File: tb/tb_par2serial_gear.sv
// tb/tb_par2serial_gear.sv - scoreboard bench for par2serial_gear (IN_W=16, OUT_W=8).
// Covers P2S_PARITY_EN when the macro is defined for both files.
module tb_par2serial_gear;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             msb_first = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
`ifdef P2S_PARITY_EN
  logic             out_parity;
`endif

  par2serial_gear #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msb_first (msb_first),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef P2S_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic             l;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: word split into RATIO slices by plain arithmetic, ordered per msb flag.
  task automatic push_word(input logic [IN_W-1:0] w, input logic msb);
    beat_t b;
    for (int i = 0; i < RATIO; i++) begin
      int sh;
      sh  = msb ? (RATIO - 1 - i) * OUT_W : i * OUT_W;
      b.d = OUT_W'(w >> sh);
      b.l = (i == RATIO - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic step(input logic iv, input logic [IN_W-1:0] d, input logic m, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    msb_first = m;
    out_ready = ordy;
    #2;
    if (rst && in_valid && in_ready) push_word(in_data, msb_first);
  endtask

  // Monitor: compares every presented beat with the scoreboard head, checks stall stability.
  logic             prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(prev_data));
          chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(out_data), 32'hxxxx_xxxx);
          end else begin
            chk("beat_data", 32'(out_data), 32'(exp_q[0].d));
            chk("beat_last", 32'(out_last), 32'(exp_q[0].l));
`ifdef P2S_PARITY_EN
            chk("beat_parity", 32'(out_parity), 32'(^exp_q[0].d));
`endif
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("idle_last", 32'(out_last), 32'd0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Single words, both orders
    step(1'b1, 16'h3524, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("msb_first_beat0", 32'(out_data), 32'h35);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("msb_first_beat1", 32'(out_data), 32'h24);
    chk("msb_first_last", 32'(out_last), 32'd1);
    step(1'b1, 16'h3524, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("lsb_first_beat0", 32'(out_data), 32'h24);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("lsb_first_beat1", 32'(out_data), 32'h35);
    step(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back words, in_ready only on the final beat
    step(1'b1, 16'h5e81, 1'b1, 1'b1);
    step(1'b1, 16'hd609, 1'b1, 1'b1);
    chk("b2b_in_ready_5e", 32'(in_ready), 32'd0);
    step(1'b1, 16'hd609, 1'b1, 1'b1);
    chk("b2b_in_ready_81", 32'(in_ready), 32'd1);
    chk("b2b_data_81", 32'(out_data), 32'h81);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("b2b_data_d6", 32'(out_data), 32'hd6);
    chk("b2b_in_ready_d6", 32'(in_ready), 32'd0);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("b2b_data_09", 32'(out_data), 32'h09);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("b2b_done_valid", 32'(out_valid), 32'd0);

    // Backpressure, then reset with a beat pending
    step(1'b1, 16'h5e81, 1'b1, 1'b1);
    repeat (3) begin
      step(1'b0, 16'hffff, 1'b0, 1'b0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h5e);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    step(1'b1, 16'hd609, 1'b1, 1'b1);
    step(1'b1, 16'hd609, 1'b1, 1'b1);
    chk("bp_resume_81", 32'(out_data), 32'h81);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("pend_data_d6", 32'(out_data), 32'hd6);
`ifdef P2S_PARITY_EN
    chk("parity_d6", 32'(out_parity), 32'd1);
`endif
    #1;
    rst = 1'b0;
    #1;
    chk("midword_rst_valid", 32'(out_valid), 32'd0);
    chk("midword_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    step(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    repeat (4) begin
      step(1'b0, '0, 1'b0, 1'b1);
      chk("post_rst_no_beat", 32'(out_valid), 32'd0);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, IN_W'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0);
    end
    repeat (3 * RATIO) step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
